// File: rtl/fp32_to_bfp_block_formatter.sv
// FP32 to block-floating-point formatter.
// Collects BLOCK_SIZE FP32 words, tracks the largest effective exponent and
// replays the block as sign + aligned magnitude with one shared exponent.
module fp32_to_bfp_block_formatter #(
    parameter int FP32WIDTH         = 32,
    parameter int FP32MANTISSAWIDTH = 23,
    parameter int FP32EXPONENTWIDTH = 8,
    parameter int BLOCK_SIZE        = 8,
    parameter int MANT_W            = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FP32WIDTH-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sign,
    output logic [MANT_W-1:0]            out_mant,
    output logic [FP32EXPONENTWIDTH-1:0] out_exp,
    output logic                         out_last,
    output logic                         out_special,
    output logic                         busy
);

    localparam int CW = $clog2(BLOCK_SIZE);
    localparam int EW = FP32EXPONENTWIDTH;
    localparam int SW = FP32MANTISSAWIDTH + 1;
    localparam logic [EW-1:0] EXP_SAT = {{(EW-1){1'b1}}, 1'b0};

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [CW-1:0]          idx;
    logic [EW-1:0]          max_exp;
    logic                   special;
    logic [FP32WIDTH-1:0]   buffer [BLOCK_SIZE];

    logic [EW-1:0]          in_exp;
    logic [EW-1:0]          in_exp_eff;
    logic [EW-1:0]          max_exp_nxt;
    logic                   special_nxt;
    logic [CW-1:0]          idx_nxt;
    logic                   in_fire;
    logic                   out_fire;

    // Aligns one stored word to the shared exponent (truncating toward zero).
    function automatic logic [MANT_W-1:0] align(input logic [FP32WIDTH-1:0] w,
                                                input logic [EW-1:0] mexp);
        logic [EW-1:0] e;
        logic [EW-1:0] shift;
        logic [SW-1:0] sig;
        logic [SW-1:0] shifted;
        e       = w[FP32WIDTH-2 -: EW];
        sig     = {1'b1, w[FP32MANTISSAWIDTH-1:0]};
        shift   = mexp - e;
        shifted = sig >> shift;
        if (e == '0)
            align = '0;
        else if (e == '1)
            align = '1;
        else if (shift >= EW'(SW))
            align = '0;
        else
            align = shifted[SW-1 -: MANT_W];
    endfunction

    assign in_ready = (state == COLLECT);
    assign busy     = (state == EMIT) || (count != '0);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Effective exponent of the incoming word and the running block max/special flags.
    always_comb begin
        in_exp      = in_data[FP32WIDTH-2 -: EW];
        in_exp_eff  = (in_exp == '1) ? EXP_SAT : in_exp;
        max_exp_nxt = (in_exp_eff > max_exp) ? in_exp_eff : max_exp;
        special_nxt = special || (in_exp == '1);
        idx_nxt     = idx + CW'(1);
    end

    // Block collection, emission sequencing and registered element outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            count       <= '0;
            idx         <= '0;
            max_exp     <= '0;
            special     <= 1'b0;
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_mant    <= '0;
            out_exp     <= '0;
            out_last    <= 1'b0;
            out_special <= 1'b0;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++)
                buffer[i] <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_fire) begin
                        buffer[count] <= in_data;
                        max_exp       <= max_exp_nxt;
                        special       <= special_nxt;
                        if (count == CW'(BLOCK_SIZE-1)) begin
                            // Element 0 is already buffered, so its output can be
                            // formed now using the max that includes the last word.
                            state       <= EMIT;
                            count       <= '0;
                            idx         <= '0;
                            out_valid   <= 1'b1;
                            out_sign    <= buffer[0][FP32WIDTH-1];
                            out_mant    <= align(buffer[0], max_exp_nxt);
                            out_exp     <= max_exp_nxt;
                            out_last    <= 1'b0;
                            out_special <= special_nxt;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (idx == CW'(BLOCK_SIZE-1)) begin
                            state       <= COLLECT;
                            idx         <= '0;
                            max_exp     <= '0;
                            special     <= 1'b0;
                            out_valid   <= 1'b0;
                            out_sign    <= 1'b0;
                            out_mant    <= '0;
                            out_exp     <= '0;
                            out_last    <= 1'b0;
                            out_special <= 1'b0;
                        end else begin
                            idx      <= idx_nxt;
                            out_sign <= buffer[idx_nxt][FP32WIDTH-1];
                            out_mant <= align(buffer[idx_nxt], max_exp);
                            out_last <= (idx_nxt == CW'(BLOCK_SIZE-1));
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_bfp_block_formatter.sv
// Testbench for fp32_to_bfp_block_formatter: scoreboard of expected elements
// built from an independent arithmetic model, compared as elements emerge.
module tb_fp32_to_bfp_block_formatter;

    localparam int MW = 8;
    localparam int BS = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [MW-1:0] out_mant;
    logic [7:0]    out_exp;
    logic          out_last;
    logic          out_special;
    logic          busy;

    typedef struct packed {
        logic          sign;
        logic [MW-1:0] mant;
        logic [7:0]    exp;
        logic          last;
        logic          special;
    } elem_t;

    elem_t       sb [$];
    logic [31:0] blk [BS];
    int          checks;
    int          errors;
    int          pops;
    bit          rand_ready;

    fp32_to_bfp_block_formatter #(
        .FP32WIDTH(32),
        .FP32MANTISSAWIDTH(23),
        .FP32EXPONENTWIDTH(8),
        .BLOCK_SIZE(BS),
        .MANT_W(MW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sign(out_sign),
        .out_mant(out_mant),
        .out_exp(out_exp),
        .out_last(out_last),
        .out_special(out_special),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: compare every transferred element against the model.
    always @(negedge clk) begin
        elem_t act;
        elem_t exp_e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            pops++;
            act = {out_sign, out_mant, out_exp, out_last, out_special};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, scoreboard empty", act);
            end else begin
                exp_e = sb.pop_front();
                if (act !== exp_e) begin
                    errors++;
                    $display("FAIL element: got s=%b m=%h e=%h l=%b sp=%b, want s=%b m=%h e=%h l=%b sp=%b",
                             act.sign, act.mant, act.exp, act.last, act.special,
                             exp_e.sign, exp_e.mant, exp_e.exp, exp_e.last, exp_e.special);
                end
            end
        end
    end

    // Model: magnitude = floor(sig / 2^(shift + 24 - MW)).
    task automatic push_model();
        int    maxe;
        int    e;
        bit    spec;
        elem_t it;
        longint sig;
        maxe = 0;
        spec = 0;
        for (int i = 0; i < BS; i++) begin
            e = int'(blk[i][30:23]);
            if (e == 255) begin
                spec = 1;
                e = 254;
            end
            if (e > maxe) maxe = e;
        end
        for (int i = 0; i < BS; i++) begin
            e = int'(blk[i][30:23]);
            it.sign    = blk[i][31];
            it.exp     = 8'(maxe);
            it.last    = (i == BS - 1);
            it.special = spec;
            if (e == 0)
                it.mant = '0;
            else if (e == 255)
                it.mant = '1;
            else begin
                sig = longint'({1'b1, blk[i][22:0]});
                it.mant = MW'(sig >> (maxe - e + 24 - MW));
            end
            sb.push_back(it);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block();
        push_model();
        for (int i = 0; i < BS; i++) send_word(blk[i]);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy, out_last, out_special, out_sign, out_mant, out_exp} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state: rdy=%b v=%b busy=%b l=%b sp=%b s=%b m=%h e=%h, want 1 0 0 0 0 0 00 00",
                     in_ready, out_valid, busy, out_last, out_special, out_sign, out_mant, out_exp);
        end
    endtask

    task automatic test_ones_latency();
        for (int i = 0; i < BS; i++) blk[i] = 32'h3F800000;
        push_model();
        for (int i = 0; i < BS - 1; i++) send_word(blk[i]);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_last: out_valid=%b busy=%b, want 0 1", out_valid, busy);
        end
        send_word(blk[BS-1]);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_exp !== 8'd127 || out_mant !== 8'h80) begin
            errors++;
            $display("FAIL latency: v=%b rdy=%b e=%h m=%h, want 1 0 7f 80", out_valid, in_ready, out_exp, out_mant);
        end
        wait_drain();
    endtask

    task automatic test_mixed();
        blk = '{32'h40800000, 32'h3F800000, 32'hBF000000, 32'h00000000,
                32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        send_block();
        wait_drain();
    endtask

    task automatic test_underflow_and_zero();
        blk = '{32'h3F800000, 32'h30800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        send_block();
        wait_drain();
        blk = '{32'h0, 32'h80000000, 32'h00000001, 32'h0, 32'h807FFFFF, 32'h0, 32'h0, 32'h0};
        send_block();
        wait_drain();
    endtask

    task automatic test_backpressure();
        elem_t snap;
        int    start;
        blk = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h40800000,
                32'h40A00000, 32'hC0C00000, 32'h40E00000, 32'h41000000};
        start = pops;
        send_block();
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        snap = {out_sign, out_mant, out_exp, out_last, out_special};
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({out_sign, out_mant, out_exp, out_last, out_special} !== snap ||
                out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got %h v=%b rdy=%b, want %h 1 0",
                         {out_sign, out_mant, out_exp, out_last, out_special}, out_valid, in_ready, snap);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (pops - start !== BS) begin
            errors++;
            $display("FAIL stall_count: got %0d elements, want %0d", pops - start, BS);
        end
    endtask

    task automatic test_special();
        blk = '{32'h3F800000, 32'h7F800000, 32'hBF800000, 32'h40000000,
                32'h0, 32'hFFC00000, 32'h3E800000, 32'h0};
        send_block();
        wait_drain();
        blk = '{32'h3F800000, 32'h3F000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        send_block();
        wait_drain();
    endtask

    task automatic test_reset_midblock();
        for (int i = 0; i < 5; i++) send_word(32'h7F000000);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midblock_reset: busy=%b rdy=%b v=%b, want 0 1 0", busy, in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        blk = '{32'h3F800000, 32'h3F000000, 32'h3FC00000, 32'hBF800000,
                32'h3E000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        send_block();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        rand_ready = 1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < BS; i++) begin
                blk[i] = $urandom;
                if ($urandom_range(0, 5) == 0) blk[i][30:23] = 8'h00;
            end
            send_block();
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        pops       = 0;
        rand_ready = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_ones_latency();
        test_mixed();
        test_underflow_and_zero();
        test_backpressure();
        test_special();
        test_reset_midblock();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: pending=%0d, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
